// File: rtl/multi_cycle_control_if.sv
`default_nettype none
// ============================================================================
// multi_cycle_control_if : instruction handshake, datapath controls and status
// Revision: 1.0
// ============================================================================
interface multi_cycle_control_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  Opcode;
  logic        Zero;
  logic        Regsel;
  logic        ALUsel;
  logic [1:0]  ALUOp;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToRegSel;
  logic        RegWrite;
  logic        branch_taken;
  logic        done;
  logic        err;
  logic        busy;
  logic [15:0] retired;

  modport master (
    output instr_valid, Opcode, Zero,
    input  instr_ready, Regsel, ALUsel, ALUOp, MemRead, MemWrite, MemToRegSel,
    input  RegWrite, branch_taken, done, err, busy, retired
  );

  modport slave (
    input  instr_valid, Opcode, Zero,
    output instr_ready, Regsel, ALUsel, ALUOp, MemRead, MemWrite, MemToRegSel,
    output RegWrite, branch_taken, done, err, busy, retired
  );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// multi_cycle_control : Moore control FSM for a multi-cycle MIPS-style datapath
// Revision: 1.0
// ============================================================================
module multi_cycle_control (
  input  logic                  clk,
  input  logic                  rst,
  multi_cycle_control_if.slave  bus
);

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE      = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE    = 4'd1;
  localparam logic [STATE_W-1:0] S_MEM_ADDR  = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_READ  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_WB    = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WRITE = 4'd5;
  localparam logic [STATE_W-1:0] S_EXEC_R    = 4'd6;
  localparam logic [STATE_W-1:0] S_R_WB      = 4'd7;
  localparam logic [STATE_W-1:0] S_BRANCH    = 4'd8;
  localparam logic [STATE_W-1:0] S_IMM_EXEC  = 4'd9;
  localparam logic [STATE_W-1:0] S_IMM_WB    = 4'd10;
  localparam logic [STATE_W-1:0] S_ILLEGAL   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  logic [STATE_W-1:0] state_q, state_d;
  logic [5:0]         opcode_q;
  logic [15:0]        retired_q;

  logic       instr_ready;
  logic       regsel;
  logic       alusel;
  logic [1:0] aluop;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       branch_taken;
  logic       done;
  logic       err;

  // The opcode is latched only on the accept edge; decode never looks at the live bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= 6'b000000;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && bus.instr_valid) begin
        opcode_q <= bus.Opcode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 16'h0000;
    end else if (done) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode_q)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_IMM_EXEC;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: state_d = S_MEM_WB;
      S_EXEC_R:   state_d = S_R_WB;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_IMM_WB, S_ILLEGAL: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // branch_taken is the one output that follows a live input (Zero) rather than state alone.
  always_comb begin
    instr_ready  = 1'b0;
    regsel       = 1'b0;
    alusel       = 1'b0;
    aluop        = ALU_ADD;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_q)
      S_IDLE: instr_ready = 1'b1;
      S_MEM_ADDR: begin
        alusel = 1'b1;
        aluop  = ALU_ADD;
      end
      S_MEM_READ: begin
        alusel   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        alusel     = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        regsel     = 1'b0;
        done       = 1'b1;
      end
      S_MEM_WRITE: begin
        alusel    = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      S_EXEC_R: begin
        alusel = 1'b0;
        aluop  = ALU_FUNC;
      end
      S_R_WB: begin
        aluop     = ALU_FUNC;
        reg_write = 1'b1;
        regsel    = 1'b1;
        done      = 1'b1;
      end
      S_BRANCH: begin
        alusel       = 1'b0;
        aluop        = ALU_SUB;
        branch_taken = bus.Zero;
        done         = 1'b1;
      end
      S_IMM_EXEC: begin
        alusel = 1'b1;
        aluop  = ALU_ADD;
      end
      S_IMM_WB: begin
        alusel    = 1'b1;
        aluop     = ALU_ADD;
        reg_write = 1'b1;
        regsel    = 1'b0;
        done      = 1'b1;
      end
      S_ILLEGAL: err = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_ready  = instr_ready;
  assign bus.busy         = !instr_ready;
  assign bus.Regsel       = regsel;
  assign bus.ALUsel       = alusel;
  assign bus.ALUOp        = aluop;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.MemToRegSel  = mem_to_reg;
  assign bus.RegWrite     = reg_write;
  assign bus.branch_taken = branch_taken;
  assign bus.done         = done;
  assign bus.err          = err;
  assign bus.retired      = retired_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_read && mem_write));
      assert (!(reg_write && mem_write));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
`default_nettype none
// tb_multi_cycle_control : vector table, corner sequences, and random traffic checked
// against a per-instruction phase model of the controller.
module tb_multi_cycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       done;
    logic       err;
    logic       bt;
    logic       regsel;
    logic       alusel;
    logic [1:0] aluop;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic       rw;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         lat;
    outs_t      fin;
    int         dret;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_cycle_control_if bus();
  multi_cycle_control dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] model_ret;
  outs_t       exp_q[$];
  bit          br_q[$];
  vec_t        tbl[8];

  function automatic outs_t mk(input logic done, input logic err, input logic bt,
                               input logic regsel, input logic alusel, input logic [1:0] aluop,
                               input logic mrd, input logic mwr, input logic m2r, input logic rw);
    outs_t o;
    o.rdy = 1'b0; o.busy = 1'b1; o.done = done; o.err = err; o.bt = bt;
    o.regsel = regsel; o.alusel = alusel; o.aluop = aluop;
    o.mrd = mrd; o.mwr = mwr; o.m2r = m2r; o.rw = rw;
    return o;
  endfunction

  function automatic outs_t idle_v();
    outs_t o;
    o = '0;
    o.rdy = 1'b1;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.rdy = bus.instr_ready; o.busy = bus.busy; o.done = bus.done; o.err = bus.err;
    o.bt = bus.branch_taken; o.regsel = bus.Regsel; o.alusel = bus.ALUsel; o.aluop = bus.ALUOp;
    o.mrd = bus.MemRead; o.mwr = bus.MemWrite; o.m2r = bus.MemToRegSel; o.rw = bus.RegWrite;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input outs_t o, input bit br);
    exp_q.push_back(o);
    br_q.push_back(br);
  endtask

  // Phase list per instruction class: DECODE first, then the class-specific cycles.
  task automatic build(input logic [5:0] op);
    exp_q.delete();
    br_q.delete();
    add(mk(0,0,0,0,0,2'b00,0,0,0,0), 0);
    case (op)
      OP_LW: begin
        add(mk(0,0,0,0,1,2'b00,0,0,0,0), 0);
        add(mk(0,0,0,0,1,2'b00,1,0,0,0), 0);
        add(mk(1,0,0,0,1,2'b00,1,0,1,1), 0);
      end
      OP_SW: begin
        add(mk(0,0,0,0,1,2'b00,0,0,0,0), 0);
        add(mk(1,0,0,0,1,2'b00,0,1,0,0), 0);
      end
      OP_RTYPE: begin
        add(mk(0,0,0,0,0,2'b10,0,0,0,0), 0);
        add(mk(1,0,0,1,0,2'b10,0,0,0,1), 0);
      end
      OP_BEQ:  add(mk(1,0,0,0,0,2'b01,0,0,0,0), 1);
      OP_ADDI: begin
        add(mk(0,0,0,0,1,2'b00,0,0,0,0), 0);
        add(mk(1,0,0,0,1,2'b00,0,0,0,1), 0);
      end
      default: add(mk(0,1,0,0,0,2'b00,0,0,0,0), 0);
    endcase
  endtask

  // Entered at a falling edge with the controller idle; leaves it idle again.
  task automatic run_instr(input logic [5:0] op, input logic hold, input logic [5:0] junk,
                           input logic rnd_zero, input logic zero);
    outs_t e;
    bus.Opcode = op;
    bus.instr_valid = 1'b1;
    bus.Zero = rnd_zero ? 1'($urandom_range(0, 1)) : zero;
    #1;
    chk($sformatf("op=%b idle before accept", op), 32'(sample()), 32'(idle_v()));
    chk($sformatf("op=%b retired before", op), 32'(bus.retired), 32'(model_ret));
    step();
    build(op);
    bus.instr_valid = hold;
    bus.Opcode = junk;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (rnd_zero) bus.Zero = 1'($urandom_range(0, 1));
      #1;
      e = exp_q[k];
      if (br_q[k]) e.bt = bus.Zero;
      chk($sformatf("op=%b cyc%0d outputs", op, k + 1), 32'(sample()), 32'(e));
      chk($sformatf("op=%b cyc%0d retired", op, k + 1), 32'(bus.retired), 32'(model_ret));
      step();
      if (e.done) model_ret = model_ret + 16'd1;
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.instr_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus.Opcode = 6'($urandom_range(0, 63));
      #1;
      chk("idle gap outputs", 32'(sample()), 32'(idle_v()));
      chk("idle gap retired", 32'(bus.retired), 32'(model_ret));
      step();
    end
  endtask

  initial begin
    int    lat;
    outs_t fin;
    logic [5:0] op;

    tbl[0] = '{OP_LW,    1'b0, 4, mk(1,0,0,0,1,2'b00,1,0,1,1), 1};
    tbl[1] = '{OP_SW,    1'b1, 3, mk(1,0,0,0,1,2'b00,0,1,0,0), 1};
    tbl[2] = '{OP_RTYPE, 1'b0, 3, mk(1,0,0,1,0,2'b10,0,0,0,1), 1};
    tbl[3] = '{OP_ADDI,  1'b1, 3, mk(1,0,0,0,1,2'b00,0,0,0,1), 1};
    tbl[4] = '{OP_BEQ,   1'b1, 2, mk(1,0,1,0,0,2'b01,0,0,0,0), 1};
    tbl[5] = '{OP_BEQ,   1'b0, 2, mk(1,0,0,0,0,2'b01,0,0,0,0), 1};
    tbl[6] = '{6'b111111, 1'b0, 2, mk(0,1,0,0,0,2'b00,0,0,0,0), 0};
    tbl[7] = '{6'b000010, 1'b1, 2, mk(0,1,0,0,0,2'b00,0,0,0,0), 0};

    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.Opcode = 6'b000000;
    bus.Zero = 1'b0;
    model_ret = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset outputs", 32'(sample()), 32'(idle_v()));
    chk("reset retired", 32'(bus.retired), 32'h0);

    // Reset wins over a simultaneous valid instruction.
    bus.instr_valid = 1'b1;
    bus.Opcode = OP_LW;
    step();
    #1;
    chk("rst over instr_valid", 32'(sample()), 32'(idle_v()));
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    step();

    // Vector table: latency, completion-cycle outputs, retired delta.
    for (int i = 0; i < 8; i++) begin
      bus.Opcode = tbl[i].op;
      bus.Zero = tbl[i].zero;
      bus.instr_valid = 1'b1;
      step();
      bus.instr_valid = 1'b0;
      bus.Opcode = ~tbl[i].op;
      lat = 0;
      fin = '0;
      for (int k = 1; k <= 8; k++) begin
        #1;
        if (bus.done || bus.err) begin
          lat = k;
          fin = sample();
          break;
        end
        step();
      end
      step();
      model_ret = model_ret + 16'(tbl[i].dret);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d final outputs", i), 32'(fin), 32'(tbl[i].fin));
      #1;
      chk($sformatf("vec%0d retired", i), 32'(bus.retired), 32'(model_ret));
      chk($sformatf("vec%0d ready after", i), 32'(bus.instr_ready), 32'h1);
    end

    // lw end to end, then beq taken / not taken.
    run_instr(OP_LW, 1'b0, 6'b000000, 1'b0, 1'b0);
    run_instr(OP_BEQ, 1'b0, 6'b000000, 1'b0, 1'b1);
    run_instr(OP_BEQ, 1'b0, 6'b000000, 1'b0, 1'b0);
    run_instr(6'b111111, 1'b0, OP_LW, 1'b0, 1'b0);
    idle_cycles(1);

    // sw aborted by reset during MEM_ADDR.
    bus.Opcode = OP_SW;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    #1;
    chk("sw abort decode", 32'(sample()), 32'(mk(0,0,0,0,0,2'b00,0,0,0,0)));
    step();
    #1;
    chk("sw abort mem_addr", 32'(sample()), 32'(mk(0,0,0,0,1,2'b00,0,0,0,0)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ret = 16'h0000;
    chk("sw abort retired cleared", 32'(bus.retired), 32'h0);
    idle_cycles(4);

    // R-type with instr_valid held and opcode switched to lw mid-flight.
    run_instr(OP_RTYPE, 1'b1, OP_LW, 1'b0, 1'b0);
    run_instr(OP_LW, 1'b0, 6'b000000, 1'b0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      idle_cycles($urandom_range(0, 2));
      case ($urandom_range(0, 6))
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b1, 1'b0);
    end

    // Counter wrap: preload to 0xFFFF, then one addi.
    idle_cycles(1);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    model_ret = 16'hFFFF;
    @(negedge clk);
    run_instr(OP_ADDI, 1'b0, 6'b000000, 1'b0, 1'b0);
    #1;
    chk("retired wrap to zero", 32'(bus.retired), 32'h0);
    @(negedge clk);
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
